// File: rtl/ddp_tx_pad_pkg.sv
// Shared definitions for the DDP transmit pad stage: word geometry,
// RDMAP opcodes and the pad FSM state type.
package ddp_tx_pad_pkg;

  localparam int DDP_WORD_W     = 267;
  localparam int DDP_BEAT_BYTES = 32;

  localparam logic [3:0] REQ_OPCODE  = 4'h1;
  localparam logic [3:0] ACK_OPCODE  = 4'h6;
  localparam logic [3:0] SEND_OPCODE = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } pad_state_e;

  // REQ and ACK are the single-beat control messages that need padding.
  function automatic logic isPadOpcode(input logic [3:0] op);
    return (op == REQ_OPCODE) || (op == ACK_OPCODE);
  endfunction

endpackage

// File: rtl/ddp_tx_pad_fifo.sv
// 32-deep, 267-bit show-ahead register FIFO feeding the framer.
// Synchronous active-low reset; simultaneous push and pop are honoured
// even when full.
module GenRegFifo32D267W
  import ddp_tx_pad_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [5:0]            almostFullThreshold,
  input  logic [5:0]            almostEmptyThreshold,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DDP_WORD_W-1:0] dataIn,
  output logic [DDP_WORD_W-1:0] dataOut,
  output logic                  empty,
  output logic                  full,
  output logic                  almostFull,
  output logic                  almostEmpty
);

  logic [DDP_WORD_W-1:0] mem [0:31];
  logic [4:0]            wr_ptr;
  logic [4:0]            rd_ptr;
  logic [5:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop      = pop & ~empty;
  assign do_push     = push & (~full | pop);
  assign empty       = (count == 6'd0);
  assign full        = (count == 6'd32);
  assign almostFull  = (count >= almostFullThreshold);
  assign almostEmpty = (count <= almostEmptyThreshold);
  assign dataOut     = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flags derive from the registered count.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 5'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 5'd1;
      count <= count + 6'(do_push) - 6'(do_pop);
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= dataIn;
  end

endmodule

// File: rtl/ddp_tx_pad.sv
// Transmit-side pad stage: pads single-beat REQ/ACK messages out to
// MIN_BEATS beats and passes every other packet straight through.
module ddp_tx_pad
  import ddp_tx_pad_pkg::*;
#(
  parameter int MIN_BEATS  = 2,
  parameter int LAST_BYTES = 32,
  parameter int CNT_W      = 16
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DDP_WORD_W-1:0] ddpPktTxDataOut,
  input  logic                  ddpPktTxEmpty,
  input  logic                  ddpPktTxDataValid,
  output logic                  ddpPktTxPop,
  input  logic                  ddpPktPadPop,
  output logic [DDP_WORD_W-1:0] ddpPktPadDataOut,
  output logic                  ddpPktPadEmpty,
  output logic                  ddpPktPadDataValid,
  output logic [CNT_W-1:0]      padCount,
  output logic                  protoErr
);

  localparam int              PAD_W    = $clog2(MIN_BEATS + 1);
  localparam logic [8:0]      LAST_BE  = 9'(LAST_BYTES);
  localparam logic [8:0]      FULL_BE  = 9'(DDP_BEAT_BYTES);
  localparam logic [PAD_W-1:0] PAD_INIT = PAD_W'(MIN_BEATS - 1);

  pad_state_e            state;
  logic [PAD_W-1:0]      padCnt;
  logic                  outFull;
  logic                  fifo_full;
  logic                  fifo_almost_full;
  logic                  fifo_empty;
  logic                  fifo_almost_empty;
  logic                  push_en;
  logic [DDP_WORD_W-1:0] push_word;
  logic                  head_valid;
  logic                  head_sop;
  logic                  head_eop;
  logic                  is_pad_op;
  logic                  pad_last;
  logic [255:0]          head_pkt;

  // A valid head should never coincide with an empty FIFO; gating on both
  // keeps a stale head word from ever being consumed.
  assign head_valid = ddpPktTxDataValid & ~ddpPktTxEmpty;
  assign head_sop   = ddpPktTxDataOut[266];
  assign head_eop   = ddpPktTxDataOut[265];
  assign head_pkt   = ddpPktTxDataOut[255:0];
  assign is_pad_op  = isPadOpcode(ddpPktTxDataOut[243:240]);
  assign pad_last   = (padCnt == PAD_W'(1));

  // At these thresholds the almost flags coincide with the hard flags.
  assign outFull            = fifo_full | fifo_almost_full;
  assign ddpPktPadEmpty     = fifo_empty | fifo_almost_empty;
  assign ddpPktPadDataValid = ~ddpPktPadEmpty;

  assign ddpPktTxPop = head_valid & ~outFull & (state != PAD);

  // Select what, if anything, gets written into the output FIFO this cycle.
  always_comb begin
    push_en   = 1'b0;
    push_word = '0;
    if (state == PAD) begin
      push_en   = ~outFull;
      push_word = {1'b0, pad_last, (pad_last ? LAST_BE : FULL_BE), 256'd0};
    end else if (ddpPktTxPop) begin
      if (head_sop && is_pad_op) begin
        push_en = 1'b1;
        if (MIN_BEATS == 1) push_word = {1'b1, 1'b1, LAST_BE, head_pkt};
        else                push_word = {1'b1, 1'b0, FULL_BE, head_pkt};
      end else if (head_sop || (state == PASS)) begin
        push_en   = 1'b1;
        push_word = ddpPktTxDataOut;
      end
    end
  end

  // Packet FSM, pad beat counter, padded-packet statistic and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      padCnt   <= '0;
      padCount <= '0;
      protoErr <= 1'b0;
    end else if (state == PAD) begin
      if (!outFull) begin
        padCnt <= padCnt - 1'b1;
        if (pad_last) begin
          padCount <= padCount + 1'b1;
          state    <= IDLE;
        end
      end
    end else if (ddpPktTxPop) begin
      if (head_sop) begin
        if (state == PASS) protoErr <= 1'b1;
        if (is_pad_op) begin
          if (MIN_BEATS == 1) begin
            padCount <= padCount + 1'b1;
            state    <= IDLE;
          end else begin
            padCnt <= PAD_INIT;
            state  <= PAD;
          end
        end else begin
          state <= head_eop ? IDLE : PASS;
        end
      end else if (state == PASS) begin
        if (head_eop) state <= IDLE;
      end else begin
        protoErr <= 1'b1;
      end
    end
  end

  GenRegFifo32D267W u_out_fifo (
    .clock                (clock),
    .resetN               (~reset),
    .almostFullThreshold  (6'd32),
    .almostEmptyThreshold (6'd0),
    .push                 (push_en),
    .pop                  (ddpPktPadPop),
    .dataIn               (push_word),
    .dataOut              (ddpPktPadDataOut),
    .empty                (fifo_empty),
    .full                 (fifo_full),
    .almostFull           (fifo_almost_full),
    .almostEmpty          (fifo_almost_empty)
  );

endmodule

// File: tb/tb_ddp_tx_pad.sv
// Scoreboard bench for ddp_tx_pad: directed upstream words, expected
// output words queued alongside, checked by an independent output monitor.
module tb_ddp_tx_pad;
  import ddp_tx_pad_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [266:0] ddpPktTxDataOut;
  logic         ddpPktTxEmpty;
  logic         ddpPktTxDataValid;
  logic         ddpPktTxPop;
  logic         ddpPktPadPop;
  logic [266:0] ddpPktPadDataOut;
  logic         ddpPktPadEmpty;
  logic         ddpPktPadDataValid;
  logic [15:0]  padCount;
  logic         protoErr;

  logic [266:0] txMem [0:255];
  int           wrIdx = 0;
  int           rdIdx = 0;
  int           popCount = 0;
  logic         popSeen = 1'b0;
  logic         drainEn;
  logic [266:0] expQ [$];
  int           checks = 0;
  int           fails = 0;

  ddp_tx_pad dut (
    .clock              (clock),
    .reset              (reset),
    .ddpPktTxDataOut    (ddpPktTxDataOut),
    .ddpPktTxEmpty      (ddpPktTxEmpty),
    .ddpPktTxDataValid  (ddpPktTxDataValid),
    .ddpPktTxPop        (ddpPktTxPop),
    .ddpPktPadPop       (ddpPktPadPop),
    .ddpPktPadDataOut   (ddpPktPadDataOut),
    .ddpPktPadEmpty     (ddpPktPadEmpty),
    .ddpPktPadDataValid (ddpPktPadDataValid),
    .padCount           (padCount),
    .protoErr           (protoErr)
  );

  always #5 clock = ~clock;

  // Upstream show-ahead FIFO model.
  assign ddpPktTxDataOut   = txMem[rdIdx];
  assign ddpPktTxEmpty     = (rdIdx == wrIdx);
  assign ddpPktTxDataValid = (rdIdx != wrIdx);
  assign ddpPktPadPop      = drainEn & ddpPktPadDataValid;

  // Sample the pop request mid-cycle, retire the head word on the edge.
  always @(negedge clock) begin
    popSeen = ddpPktTxPop;
    if (ddpPktTxPop) popCount++;
  end

  always @(posedge clock) begin
    if (popSeen) rdIdx <= rdIdx + 1;
  end

  function automatic logic [266:0] mk(input logic sop, input logic eop,
                                      input logic [8:0] be, input logic [255:0] pkt);
    return {sop, eop, be, pkt};
  endfunction

  function automatic logic [255:0] sopPkt(input logic [3:0] op, input logic [31:0] fill);
    return {8'hA5, 4'h0, op, {7{fill}}, 16'h0};
  endfunction

  task automatic checkOutput(input string name, input logic [266:0] actual,
                             input logic [266:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every word the downstream consumes must match the scoreboard head.
  always @(negedge clock) begin
    if (ddpPktPadPop) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL outWord unexpected actual=%0h expected=none", ddpPktPadDataOut);
      end else begin
        checkOutput("outWord", ddpPktPadDataOut, expQ.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [266:0] word);
    txMem[wrIdx] = word;
    wrIdx++;
  endtask

  task automatic expectWord(input logic [266:0] word);
    expQ.push_back(word);
  endtask

  // Bounded wait for the upstream (and optionally the scoreboard) to drain.
  task automatic waitIdle(input string name, input logic includeOut);
    int n = 0;
    while (((rdIdx != wrIdx) || (includeOut && expQ.size() != 0)) && n < 1000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      fails++;
      $display("[TB] FAIL %s timeout actual=busy expected=drained", name);
    end
    tick(2);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    reset   = 1'b1;
    drainEn = 1'b0;
    tick(3);
    checkOutput("resetEmpty", 267'(ddpPktPadEmpty), 267'(1));
    checkOutput("resetPadCount", 267'(padCount), 267'(0));
    checkOutput("resetProtoErr", 267'(protoErr), 267'(0));
    checkOutput("resetTxPop", 267'(ddpPktTxPop), 267'(0));
    reset = 1'b0;
    tick(1);

    // REQ with eop and be=10 becomes a full first beat plus one pad beat.
    $display("[TB] test1 REQ pad");
    drainEn = 1'b1;
    p0 = popCount;
    applyStimulus(mk(1'b1, 1'b1, 9'd10, sopPkt(REQ_OPCODE, 32'h1111_0001)));
    expectWord(mk(1'b1, 1'b0, 9'd32, sopPkt(REQ_OPCODE, 32'h1111_0001)));
    expectWord(mk(1'b0, 1'b1, 9'd32, 256'd0));
    waitIdle("t1Drain", 1'b1);
    checkOutput("t1PadCount", 267'(padCount), 267'(1));
    checkOutput("t1Pops", 267'(popCount - p0), 267'(1));

    // Three-beat SEND passes through untouched.
    $display("[TB] test2 SEND passthrough");
    applyStimulus(mk(1'b1, 1'b0, 9'd32, sopPkt(SEND_OPCODE, 32'h2222_0001)));
    applyStimulus(mk(1'b0, 1'b0, 9'd32, {8{32'h2222_0002}}));
    applyStimulus(mk(1'b0, 1'b1, 9'd7,  {8{32'h2222_0003}}));
    expectWord(mk(1'b1, 1'b0, 9'd32, sopPkt(SEND_OPCODE, 32'h2222_0001)));
    expectWord(mk(1'b0, 1'b0, 9'd32, {8{32'h2222_0002}}));
    expectWord(mk(1'b0, 1'b1, 9'd7,  {8{32'h2222_0003}}));
    waitIdle("t2Drain", 1'b1);
    checkOutput("t2PadCount", 267'(padCount), 267'(1));

    // Fill the output FIFO, then an ACK must wait for room.
    $display("[TB] test3 backpressure");
    drainEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(mk(1'b1, 1'b1, 9'd32, sopPkt(SEND_OPCODE, 32'h3300_0000 + i)));
      expectWord(mk(1'b1, 1'b1, 9'd32, sopPkt(SEND_OPCODE, 32'h3300_0000 + i)));
    end
    waitIdle("t3Fill", 1'b0);
    checkOutput("t3NotEmpty", 267'(ddpPktPadEmpty), 267'(0));
    applyStimulus(mk(1'b1, 1'b1, 9'd16, sopPkt(ACK_OPCODE, 32'h3333_AAAA)));
    expectWord(mk(1'b1, 1'b0, 9'd32, sopPkt(ACK_OPCODE, 32'h3333_AAAA)));
    expectWord(mk(1'b0, 1'b1, 9'd32, 256'd0));
    tick(3);
    checkOutput("t3TxPopFull", 267'(ddpPktTxPop), 267'(0));
    checkOutput("t3AckHeld", 267'(rdIdx != wrIdx), 267'(1));
    drainEn = 1'b1;
    tick(1);
    drainEn = 1'b0;
    tick(4);
    checkOutput("t3AckTaken", 267'(rdIdx == wrIdx), 267'(1));
    checkOutput("t3PadPending", 267'(padCount), 267'(1));
    drainEn = 1'b1;
    waitIdle("t3Drain", 1'b1);
    checkOutput("t3PadCount", 267'(padCount), 267'(2));

    // A sop arriving mid-packet flags an error but is still processed.
    $display("[TB] test5 sop inside packet");
    checkOutput("t5ErrBefore", 267'(protoErr), 267'(0));
    applyStimulus(mk(1'b1, 1'b0, 9'd32, sopPkt(SEND_OPCODE, 32'h5555_0001)));
    applyStimulus(mk(1'b1, 1'b0, 9'd5,  sopPkt(REQ_OPCODE,  32'h5555_0002)));
    applyStimulus(mk(1'b1, 1'b1, 9'd8,  sopPkt(SEND_OPCODE, 32'h5555_0003)));
    expectWord(mk(1'b1, 1'b0, 9'd32, sopPkt(SEND_OPCODE, 32'h5555_0001)));
    expectWord(mk(1'b1, 1'b0, 9'd32, sopPkt(REQ_OPCODE,  32'h5555_0002)));
    expectWord(mk(1'b0, 1'b1, 9'd32, 256'd0));
    expectWord(mk(1'b1, 1'b1, 9'd8,  sopPkt(SEND_OPCODE, 32'h5555_0003)));
    waitIdle("t5Drain", 1'b1);
    checkOutput("t5ProtoErr", 267'(protoErr), 267'(1));
    checkOutput("t5PadCount", 267'(padCount), 267'(3));

    // A stray non-sop word in IDLE is dropped; following SEND is intact.
    $display("[TB] test4 stray word");
    applyStimulus(mk(1'b0, 1'b1, 9'd32, {8{32'h4444_DEAD}}));
    applyStimulus(mk(1'b1, 1'b1, 9'd20, sopPkt(SEND_OPCODE, 32'h4444_0001)));
    expectWord(mk(1'b1, 1'b1, 9'd20, sopPkt(SEND_OPCODE, 32'h4444_0001)));
    waitIdle("t4Drain", 1'b1);
    checkOutput("t4ProtoErr", 267'(protoErr), 267'(1));
    tick(3);
    checkOutput("t4ProtoErrSticky", 267'(protoErr), 267'(1));

    // Reset while parked in PAD: everything returns to its initial state.
    $display("[TB] test6 reset in PAD");
    drainEn = 1'b0;
    for (int i = 0; i < 31; i++) begin
      applyStimulus(mk(1'b1, 1'b1, 9'd32, sopPkt(SEND_OPCODE, 32'h6600_0000 + i)));
    end
    applyStimulus(mk(1'b1, 1'b1, 9'd32, sopPkt(REQ_OPCODE, 32'h6666_0001)));
    waitIdle("t6Fill", 1'b0);
    checkOutput("t6PadStalled", 267'(padCount), 267'(3));
    reset = 1'b1;
    expQ.delete();
    tick(1);
    reset = 1'b0;
    checkOutput("t6Empty", 267'(ddpPktPadEmpty), 267'(1));
    checkOutput("t6PadCount", 267'(padCount), 267'(0));
    checkOutput("t6ProtoErr", 267'(protoErr), 267'(0));
    drainEn = 1'b1;
    applyStimulus(mk(1'b1, 1'b1, 9'd3, sopPkt(REQ_OPCODE, 32'h6666_0002)));
    expectWord(mk(1'b1, 1'b0, 9'd32, sopPkt(REQ_OPCODE, 32'h6666_0002)));
    expectWord(mk(1'b0, 1'b1, 9'd32, 256'd0));
    waitIdle("t6Drain", 1'b1);
    checkOutput("t6PadAfter", 267'(padCount), 267'(1));
    checkOutput("t6EmptyAfter", 267'(ddpPktPadEmpty), 267'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
